// File: rtl/pipeline_hazard_unit.sv
// Interlock, forwarding and flush controller: a shift-register scoreboard of
// in-flight records after decode drives load-use stalls, operand forward selects and redirect flushes.
module pipeline_hazard_unit #(
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 1,
    parameter int REG_IDX_W  = 5,
    parameter int CNT_W      = 16,
    localparam int FWD_W     = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_src1_idx,
    input  logic [REG_IDX_W-1:0] id_src2_idx,
    input  logic                 id_src1_used,
    input  logic                 id_src2_used,
    input  logic [REG_IDX_W-1:0] id_dest_idx,
    input  logic                 id_dest_we,
    input  logic                 id_is_load,
    input  logic                 ex_redirect,
    output logic                 issue,
    output logic                 stall_if_id,
    output logic                 flush_if_id,
    output logic [FWD_W-1:0]     fwd_sel1,
    output logic [FWD_W-1:0]     fwd_sel2,
    output logic [DEPTH-1:0]     stage_valid,
    output logic [CNT_W-1:0]     stall_count,
    output logic [CNT_W-1:0]     flush_count
);

    logic [DEPTH-1:0]     sb_valid_reg;
    logic [DEPTH-1:0]     sb_we_reg;
    logic [DEPTH-1:0]     sb_load_reg;
    logic [REG_IDX_W-1:0] sb_dest_reg [DEPTH];
    logic                 run_reg;
    logic [CNT_W-1:0]     stall_count_reg;
    logic [CNT_W-1:0]     flush_count_reg;

    logic [DEPTH-1:0]     match1;
    logic [DEPTH-1:0]     match2;
    logic [FWD_W-1:0]     sel1_raw;
    logic [FWD_W-1:0]     sel2_raw;
    logic                 load_use1;
    logic                 load_use2;
    logic                 load_use;
    logic                 redirect_acc;

    // An empty decode slot never matches, so it can neither stall nor forward.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_match
            assign match1[gi] = id_valid && id_src1_used && (id_src1_idx != '0) &&
                                sb_valid_reg[gi] && sb_we_reg[gi] &&
                                (sb_dest_reg[gi] == id_src1_idx);
            assign match2[gi] = id_valid && id_src2_used && (id_src2_idx != '0) &&
                                sb_valid_reg[gi] && sb_we_reg[gi] &&
                                (sb_dest_reg[gi] == id_src2_idx);
        end
    endgenerate

    // Scan oldest to youngest so the youngest producer is the last one written.
    always_comb begin
        sel1_raw  = '0;
        sel2_raw  = '0;
        load_use1 = 1'b0;
        load_use2 = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (match1[k]) begin
                sel1_raw  = FWD_W'(k + 1);
                load_use1 = sb_load_reg[k] && (k < LOAD_STAGE);
            end
            if (match2[k]) begin
                sel2_raw  = FWD_W'(k + 1);
                load_use2 = sb_load_reg[k] && (k < LOAD_STAGE);
            end
        end
    end

    assign load_use     = load_use1 || load_use2;
    assign redirect_acc = run_reg && ex_redirect && sb_valid_reg[0];

    assign flush_if_id = redirect_acc;
    assign stall_if_id = run_reg && !redirect_acc && load_use && id_valid;
    assign issue       = run_reg && !redirect_acc && !load_use && id_valid;
    assign fwd_sel1    = load_use ? '0 : sel1_raw;
    assign fwd_sel2    = load_use ? '0 : sel2_raw;
    assign stage_valid = sb_valid_reg;
    assign stall_count = stall_count_reg;
    assign flush_count = flush_count_reg;

    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sb_valid_reg[gi] <= 1'b0;
                    sb_we_reg[gi]    <= 1'b0;
                    sb_load_reg[gi]  <= 1'b0;
                    sb_dest_reg[gi]  <= '0;
                end else if (gi == 0) begin
                    sb_valid_reg[gi] <= issue;
                    sb_we_reg[gi]    <= id_dest_we;
                    sb_load_reg[gi]  <= id_is_load;
                    sb_dest_reg[gi]  <= id_dest_idx;
                end else begin
                    sb_valid_reg[gi] <= sb_valid_reg[gi-1];
                    sb_we_reg[gi]    <= sb_we_reg[gi-1];
                    sb_load_reg[gi]  <= sb_load_reg[gi-1];
                    sb_dest_reg[gi]  <= sb_dest_reg[gi-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_reg         <= 1'b0;
            stall_count_reg <= '0;
            flush_count_reg <= '0;
        end else begin
            run_reg <= 1'b1;
            if (stall_if_id && (stall_count_reg != '1)) begin
                stall_count_reg <= stall_count_reg + 1'b1;
            end
            if (redirect_acc && (flush_count_reg != '1)) begin
                flush_count_reg <= flush_count_reg + 1'b1;
            end
        end
    end

endmodule

// File: doc/pipeline_hazard_unit.md
# pipeline_hazard_unit

Parametrised interlock, forwarding and flush controller for the pipelined core. It tracks every in-flight instruction after decode in a per-stage scoreboard of configurable depth. From that scoreboard it derives load-use stalls, per-operand forwarding selects and wrong-path flushes on branch redirect. It sits beside InstructionDecode, drives the IF/ID hold/flush controls and the Execute operand muxes, and keeps stall and flush performance counters.

## Interface
- DEPTH, 3: scoreboard stages after decode (0 = EX output, 1 = MA output, 2 = WB); legal range ≥ 2
- LOAD_STAGE, 1: first stage whose output holds load data; legal range 0 to DEPTH-1
- REG_IDX_W, 5: register index width
- CNT_W, 16: performance counter width
- Derived FWD_W = $clog2(DEPTH+1)

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode holds a valid instruction
- id_src1_idx, id_src2_idx  in  REG_IDX_W  source register indices
- id_src1_used, id_src2_used  in  1  source is actually read
- id_dest_idx  in  REG_IDX_W  destination index
- id_dest_we  in  1  instruction writes its destination
- id_is_load  in  1  instruction is a load
- ex_redirect  in  1  branch in EX resolved mispredicted
- issue  out  1  ID instruction enters stage 0 this cycle
- stall_if_id  out  1  hold the IF and ID registers
- flush_if_id  out  1  invalidate the IF and ID registers
- fwd_sel1, fwd_sel2  out  FWD_W  0 = register file; k = stage k-1 output
- stage_valid  out  DEPTH  valid bit of each scoreboard stage
- stall_count  out  CNT_W  load-use stall cycles, saturating
- flush_count  out  CNT_W  accepted redirects, saturating

## Operation
- Record per stage: valid, dest, we, is_load.
- Every clock, stage k+1 takes stage k and stage DEPTH-1 retires.
- Stage 0 takes the ID record when issue=1; otherwise it takes a bubble (valid=0).
- Match(src, k) requires all of the following:
  - src_used=1 and src index ≠ 0 (register 0 never hazards).
  - stage k has valid=1 and we=1.
  - stage k dest equals the src index.
- Forwarding: fwd_sel = k+1 for the smallest matching k (youngest producer wins); 0 when nothing matches.
- Load-use: if the youngest match for either source is a load with k < LOAD_STAGE, load_use=1 and both fwd_sel outputs are forced to 0.
- Redirect is accepted only when ex_redirect=1 and stage_valid[0]=1; otherwise ex_redirect is ignored.
- Priority: redirect over load-use.
  - redirect: flush_if_id=1, stall_if_id=0, issue=0.
  - otherwise load-use with id_valid=1: stall_if_id=1, issue=0.
  - otherwise issue = id_valid.
- A bubble is never checked for hazards.
- Counters increment by 1 per qualifying cycle and saturate at 2^CNT_W-1.
  - stall_count counts cycles with stall_if_id=1.
  - flush_count counts cycles with an accepted redirect.
- Registered run bit: cleared by reset, set on the first clock after rst_n rises. issue, stall_if_id and flush_if_id are forced to 0 while run=0.

## Timing
- issue, stall_if_id, flush_if_id and fwd_sel are combinational from the current inputs and state, with no added latency.
- Scoreboard, counters and run bit update on the rising edge of clk.
- Reset values (asynchronous): all stages invalid, stage_valid=0, counters 0, run=0, so every output is 0.
- Reset asserted mid-operation clears in-flight records immediately. Forwards and stalls drop in the same cycle.
- Load-use stall length is LOAD_STAGE-k cycles. With defaults, a load in stage 0 gives 1 stall cycle, then fwd_sel=2.
- An instruction issued at cycle t occupies stage k during cycle t+1+k.
- A flushed ID instruction never enters the scoreboard. The redirecting branch itself proceeds normally.

## Test plan
- Reset: drive id_valid=1 and ex_redirect=1 with rst_n=0 -> all outputs 0. First cycle after release -> issue=0. Second cycle -> issue=1.
- ALU back-to-back: issue dest r3 (we=1, load=0), next ID reads src1=r3 -> fwd_sel1=1, stall_if_id=0. Following cycle -> fwd_sel1=2, then 3, then 0.
- Load-use: issue load to r4, next ID reads src2=r4 -> stall_if_id=1 for one cycle, stage_valid=3'b010 afterwards, fwd_sel2=2, stall_count=1.
- Redirect: branch in stage 0, ex_redirect=1, ID load-use pending -> flush_if_id=1, stall_if_id=0, issue=0, flush_count=1, stall_count unchanged, stage 0 bubble next cycle.
- Priority and r0: r5 valid in stages 0 and 2 -> fwd_sel=1. Dest r0 in stage 0 read by ID -> fwd_sel=0, no stall. ex_redirect with stage_valid[0]=0 -> ignored.
- Saturation: CNT_W=4, 20 load-use stall cycles -> stall_count holds 15.
